// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared CPU widths and writeback record
package wb_arbiter_pkg;

   localparam int REG_IDX_W = 5;
   localparam int XLEN      = 32;

   // Writeback record shared by EX/MEM stages, the ID hazard unit and the arbiter
   typedef struct packed {
      logic                 valid;
      logic [REG_IDX_W-1:0] rd;
      logic [XLEN-1:0]      data;
   } wb_rec_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter bus: pipeline, MDU and register-file port
interface wb_arbiter_if #(
   parameter int DEPTH = 4
);
   import wb_arbiter_pkg::*;

   logic                   pipe_valid;
   logic [REG_IDX_W-1:0]   pipe_rd;
   logic [XLEN-1:0]        pipe_data;
   logic                   mdu_valid;
   logic                   mdu_ready;
   logic [REG_IDX_W-1:0]   mdu_rd;
   logic [XLEN-1:0]        mdu_data;
   logic                   RegWrite;
   logic [REG_IDX_W-1:0]   Write_register;
   logic [XLEN-1:0]        Write_data;
   logic [(1<<REG_IDX_W)-1:0] pending_mask;
   logic [$clog2(DEPTH):0] fifo_count;

   // Producer side: pipeline, MDU and whoever observes the register-file port
   modport master (
      output pipe_valid, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
      input  mdu_ready, RegWrite, Write_register, Write_data, pending_mask, fifo_count
   );

   // Arbiter side
   modport slave (
      input  pipe_valid, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
      output mdu_ready, RegWrite, Write_register, Write_data, pending_mask, fifo_count
   );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO with count/full/empty and a per-slot tag view
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37,
   parameter int TAG_W = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic [WIDTH-1:0]            push_data,
   input  logic                        pop,
   output logic [WIDTH-1:0]            head,
   output logic [DEPTH-1:0][TAG_W-1:0] tags,
   output logic [DEPTH-1:0]            occupied,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        full,
   output logic                        empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Expose the top TAG_W bits of every slot so the owner can decode occupancy per key
   always_comb begin
      tags = '0;
      for (int i = 0; i < DEPTH; i++) begin
         tags[i] = mem[i][WIDTH-1 -: TAG_W];
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; occupied tracks live slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         occupied <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr           <= wr_ptr + PW'(1);
            occupied[wr_ptr] <= 1'b1;
         end
         if (pop_ok) begin
            rd_ptr           <= rd_ptr + PW'(1);
            occupied[rd_ptr] <= 1'b0;
         end
         if (push_ok && !pop_ok) begin
            count <= count + CW'(1);
         end else if (pop_ok && !push_ok) begin
            count <= count - CW'(1);
         end
      end
   end

   // Storage needs no reset: a slot is only read while occupied
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter for pipeline and MDU results
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   wb_arbiter_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = REG_IDX_W + XLEN;

   logic                            push;
   logic                            pop;
   logic                            full;
   logic                            empty;
   logic                            accept;
   logic [CW-1:0]                   count;
   logic [EW-1:0]                   head;
   logic [DEPTH-1:0][REG_IDX_W-1:0] slot_rd;
   logic [DEPTH-1:0]                occupied;
   logic [(1<<REG_IDX_W)-1:0]       mask;
   wb_rec_t                         sel;

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW),
      .TAG_W (REG_IDX_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data ({bus.mdu_rd, bus.mdu_data}),
      .pop       (pop),
      .head      (head),
      .tags      (slot_rd),
      .occupied  (occupied),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Ready depends only on registered occupancy, so a same-cycle pop never raises it
   assign bus.mdu_ready  = !full;
   assign bus.fifo_count = count;
   assign accept         = bus.mdu_valid && !full;

   // Commit source: pipeline first, then FIFO head, then an MDU bypass into an idle port
   always_comb begin
      sel  = '0;
      push = 1'b0;
      pop  = 1'b0;
      if (bus.pipe_valid) begin
         sel.valid = 1'b1;
         sel.rd    = bus.pipe_rd;
         sel.data  = bus.pipe_data;
         push      = accept;
      end else if (!empty) begin
         sel.valid = 1'b1;
         sel.rd    = head[EW-1 -: REG_IDX_W];
         sel.data  = head[XLEN-1:0];
         pop       = 1'b1;
         push      = accept;
      end else if (accept) begin
         sel.valid = 1'b1;
         sel.rd    = bus.mdu_rd;
         sel.data  = bus.mdu_data;
      end
   end

   // Output register; an rd=0 commit is consumed but never raises the write enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.RegWrite       <= 1'b0;
         bus.Write_register <= '0;
         bus.Write_data     <= '0;
      end else begin
         bus.RegWrite <= sel.valid && (sel.rd != '0);
         if (sel.valid && (sel.rd != '0)) begin
            bus.Write_register <= sel.rd;
            bus.Write_data     <= sel.data;
         end
      end
   end

   // Pending registers: every queued destination plus the write currently on the port
   always_comb begin
      mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occupied[i]) begin
            mask[slot_rd[i]] = 1'b1;
         end
      end
      if (bus.RegWrite) begin
         mask[bus.Write_register] = 1'b1;
      end
      mask[0] = 1'b0;
   end

   assign bus.pending_mask = mask;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed bench for wb_arbiter against a queue model
module tb_wb_arbiter;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   ent_t        q[$];
   logic        exp_we;
   logic [4:0]  exp_wr;
   logic [31:0] exp_wd;
   logic        acc;
   logic [4:0]  mrd;

   wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

   wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      m = '0;
      foreach (q[i]) m[q[i].rd] = 1'b1;
      if (exp_we) m[exp_wr] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   // One clock: drive inputs, check registered state at negedge, then advance the model
   task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] md_rd, input logic [31:0] md,
                       output logic accepted);
      logic        ready;
      logic        have;
      logic [4:0]  crd;
      logic [31:0] cd;
      ent_t        e;
      bus.pipe_valid = pv;
      bus.pipe_rd    = prd;
      bus.pipe_data  = pd;
      bus.mdu_valid  = mv;
      bus.mdu_rd     = md_rd;
      bus.mdu_data   = md;
      @(negedge clk);
      check("regwrite", 64'(bus.RegWrite), 64'(exp_we));
      if (exp_we) begin
         check("write_register", 64'(bus.Write_register), 64'(exp_wr));
         check("write_data", 64'(bus.Write_data), 64'(exp_wd));
      end
      check("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
      check("mdu_ready", 64'(bus.mdu_ready), 64'(q.size() != DEPTH));
      check("pending_mask", 64'(bus.pending_mask), 64'(model_mask()));
      ready    = (q.size() != DEPTH);
      accepted = mv && ready;
      e.rd     = md_rd;
      e.data   = md;
      have     = 1'b0;
      crd      = '0;
      cd       = '0;
      if (pv) begin
         have = 1'b1;
         crd  = prd;
         cd   = pd;
         if (accepted) q.push_back(e);
      end else if (q.size() != 0) begin
         have = 1'b1;
         crd  = q[0].rd;
         cd   = q[0].data;
         void'(q.pop_front());
         if (accepted) q.push_back(e);
      end else if (accepted) begin
         have = 1'b1;
         crd  = md_rd;
         cd   = md;
      end
      exp_we = have && (crd != 5'd0);
      if (exp_we) begin
         exp_wr = crd;
         exp_wd = cd;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      exp_we   = 1'b0;
      exp_wr   = '0;
      exp_wd   = '0;
      rst_n    = 1'b0;
      bus.pipe_valid = 1'b0;
      bus.pipe_rd    = '0;
      bus.pipe_data  = '0;
      bus.mdu_valid  = 1'b0;
      bus.mdu_rd     = '0;
      bus.mdu_data   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_regwrite", 64'(bus.RegWrite), 64'd0);
      check("rst_mdu_ready", 64'(bus.mdu_ready), 64'd1);
      check("rst_pending", 64'(bus.pending_mask), 64'd0);
      rst_n = 1'b1;

      // Bypass into an idle port
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, acc);
      check("bypass_wr", 64'(bus.Write_register), 64'd5);
      check("bypass_wd", 64'(bus.Write_data), 64'h1234);
      check("bypass_mask", 64'(bus.pending_mask), 64'h20);
      check("bypass_count", 64'(bus.fifo_count), 64'd0);
      idle(2);

      // Pipeline wins; MDU result queued then written next
      step(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB, acc);
      check("coll_wr", 64'(bus.Write_register), 64'd3);
      check("coll_mask7", 64'(bus.pending_mask[7]), 64'd1);
      idle(1);
      check("coll_wr2", 64'(bus.Write_register), 64'd7);
      check("coll_wd2", 64'(bus.Write_data), 64'hB);
      idle(1);
      check("coll_mask0", 64'(bus.pending_mask), 64'd0);

      // Fill under a busy pipeline, then drain while rd=12 waits for space
      mrd = 5'd8;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 5'd20, 32'(i), 1'b1, mrd, 32'(100 + mrd), acc);
         if (acc) mrd = mrd + 5'd1;
      end
      check("full_ready", 64'(bus.mdu_ready), 64'd0);
      check("full_count", 64'(bus.fifo_count), 64'd4);
      for (int i = 0; i < 8 && mrd != 5'd13; i++) begin
         step(1'b0, 5'd0, 32'd0, 1'b1, mrd, 32'(100 + mrd), acc);
         if (acc) mrd = mrd + 5'd1;
      end
      check("full_drained12", 64'(mrd), 64'd13);
      idle(6);

      // rd=0 MDU result behind a pipeline write
      step(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'hFFFF, acc);
      idle(3);

      // Push and pop in the same cycle keep the count
      step(1'b1, 5'd1, 32'h11, 1'b1, 5'd21, 32'h2121, acc);
      step(1'b1, 5'd2, 32'h22, 1'b1, 5'd22, 32'h2222, acc);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd23, 32'h2323, acc);
      check("pushpop_count", 64'(bus.fifo_count), 64'd2);
      idle(4);

      // Asynchronous reset with three entries queued
      for (int i = 0; i < 3; i++) step(1'b1, 5'(24 + i), 32'(i), 1'b1, 5'(13 + i), 32'(i), acc);
      bus.pipe_valid = 1'b0;
      bus.mdu_valid  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mrst_regwrite", 64'(bus.RegWrite), 64'd0);
      check("mrst_wr", 64'(bus.Write_register), 64'd0);
      check("mrst_wd", 64'(bus.Write_data), 64'd0);
      check("mrst_count", 64'(bus.fifo_count), 64'd0);
      check("mrst_pending", 64'(bus.pending_mask), 64'd0);
      check("mrst_ready", 64'(bus.mdu_ready), 64'd1);
      q.delete();
      exp_we = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(4);

      // Randomized traffic with varying pipeline and MDU load
      for (int blk = 0; blk < 8; blk++) begin
         int pp;
         int mp;
         pp = $urandom_range(10, 90);
         mp = $urandom_range(20, 90);
         for (int i = 0; i < 50; i++) begin
            step(1'($urandom_range(0, 99) < pp), 5'($urandom), $urandom,
                 1'($urandom_range(0, 99) < mp), 5'($urandom), $urandom, acc);
         end
      end
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
